// File: rtl/riscv_pkg.sv
// Shared types for the retirement tracer: the trace record layout and counter widths.
package riscv_pkg;

    localparam int unsigned REC_XLEN     = 32;
    localparam int unsigned REC_SEQ_W    = 32;
    localparam int unsigned TRACE_DROP_W = 16;

    // Field widths here must match the XLEN/SEQ_W the tracer is built with.
    typedef struct packed {
        logic [REC_SEQ_W-1:0] seq;
        logic [REC_XLEN-1:0]  pc;
        logic [REC_XLEN-1:0]  instr;
        logic                 rd_we;
        logic [4:0]           rd;
        logic [REC_XLEN-1:0]  rd_data;
        logic                 mem_we;
        logic [REC_XLEN-1:0]  mem_addr;
        logic [REC_XLEN-1:0]  mem_data;
    } trace_rec_t;

endpackage

// File: rtl/riscv_retire_tracer_if.sv
// Trace record stream from the tracer (master) to a debug/log sink (slave).
interface riscv_retire_tracer_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned SEQ_W = 32
) ();
    logic             trace_valid;
    logic             trace_ready;
    logic [SEQ_W-1:0] trace_seq;
    logic [XLEN-1:0]  trace_pc;
    logic [XLEN-1:0]  trace_instr;
    logic             trace_rd_we;
    logic [4:0]       trace_rd;
    logic [XLEN-1:0]  trace_rd_data;
    logic             trace_mem_we;
    logic [XLEN-1:0]  trace_mem_addr;
    logic [XLEN-1:0]  trace_mem_data;

    modport master (
        output trace_valid, trace_seq, trace_pc, trace_instr, trace_rd_we, trace_rd,
               trace_rd_data, trace_mem_we, trace_mem_addr, trace_mem_data,
        input  trace_ready
    );

    modport slave (
        input  trace_valid, trace_seq, trace_pc, trace_instr, trace_rd_we, trace_rd,
               trace_rd_data, trace_mem_we, trace_mem_addr, trace_mem_data,
        output trace_ready
    );
endinterface

// File: rtl/trace_fifo.sv
// Generic first-word-fall-through FIFO; head data reads as zero while empty.
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        pop_ok   = pop_i && !empty_o;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_ok  = push_i && (!full_o || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/riscv_retire_tracer.sv
// Builds one trace record per retired instruction, buffers it and streams it to a sink.
module riscv_retire_tracer
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SEQ_W = 32
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       update_i,
    input  logic [XLEN-1:0]            pc_i,
    input  logic [XLEN-1:0]            instr_i,
    input  logic [4:0]                 reg_addr_i,
    input  logic [XLEN-1:0]            reg_data_i,
    input  logic                       mem_wrt_i,
    input  logic [XLEN-1:0]            mem_addr_i,
    input  logic [XLEN-1:0]            mem_data_i,
    input  logic                       flush_i,
    riscv_retire_tracer_if.master      trace_if,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [TRACE_DROP_W-1:0]    drop_cnt_o
);
    logic                    pending_q, pending_d;
    logic [XLEN-1:0]         pend_addr_q, pend_addr_d;
    logic [XLEN-1:0]         pend_data_q, pend_data_d;
    logic [SEQ_W-1:0]        seq_q, seq_d;
    logic [TRACE_DROP_W-1:0] drop_q, drop_d;

    trace_rec_t rec;
    trace_rec_t head;
    logic       fifo_full, fifo_empty, fifo_pop, fifo_push;

    always_comb begin
        rec          = '0;
        rec.seq      = seq_q;
        rec.pc       = pc_i;
        rec.instr    = instr_i;
        rec.rd_we    = (reg_addr_i != 5'd0);
        rec.rd       = reg_addr_i;
        rec.rd_data  = reg_data_i;
        if (mem_wrt_i) begin
            rec.mem_we   = 1'b1;
            rec.mem_addr = mem_addr_i;
            rec.mem_data = mem_data_i;
        end else if (pending_q) begin
            rec.mem_we   = 1'b1;
            rec.mem_addr = pend_addr_q;
            rec.mem_data = pend_data_q;
        end
    end

    assign fifo_pop  = !fifo_empty && trace_if.trace_ready;
    assign fifo_push = update_i && !flush_i;

    always_comb begin
        pending_d   = pending_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        seq_d       = seq_q;
        drop_d      = drop_q;

        if (update_i || flush_i) begin
            pending_d = 1'b0;
        end else if (mem_wrt_i) begin
            pending_d   = 1'b1;
            pend_addr_d = mem_addr_i;
            pend_data_d = mem_data_i;
        end

        // Sequence advances even for dropped/flushed records so gaps reveal loss.
        if (update_i) seq_d = seq_q + SEQ_W'(1);

        if (fifo_push && fifo_full && !fifo_pop && (drop_q != '1)) begin
            drop_d = drop_q + TRACE_DROP_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pending_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            seq_q       <= '0;
            drop_q      <= '0;
        end else begin
            pending_q   <= pending_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            seq_q       <= seq_d;
            drop_q      <= drop_d;
        end
    end

    trace_fifo #(
        .WIDTH ($bits(trace_rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (flush_i),
        .wdata_i (rec),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    assign drop_cnt_o              = drop_q;
    assign trace_if.trace_valid    = !fifo_empty;
    assign trace_if.trace_seq      = head.seq;
    assign trace_if.trace_pc       = head.pc;
    assign trace_if.trace_instr    = head.instr;
    assign trace_if.trace_rd_we    = head.rd_we;
    assign trace_if.trace_rd       = head.rd;
    assign trace_if.trace_rd_data  = head.rd_data;
    assign trace_if.trace_mem_we   = head.mem_we;
    assign trace_if.trace_mem_addr = head.mem_addr;
    assign trace_if.trace_mem_data = head.mem_data;
endmodule

// File: tb/tb_riscv_retire_tracer.sv
// Directed plus randomized bench for riscv_retire_tracer against a queue-based reference model.
module tb_riscv_retire_tracer;
    localparam int unsigned DEPTH = 8;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        update_i, mem_wrt_i, flush_i;
    logic [31:0] pc_i, instr_i, reg_data_i, mem_addr_i, mem_data_i;
    logic [4:0]  reg_addr_i;
    logic [3:0]  count_o;
    logic [15:0] drop_cnt_o;

    riscv_retire_tracer_if #(.XLEN(32), .SEQ_W(32)) tif ();

    riscv_retire_tracer #(.XLEN(32), .DEPTH(DEPTH), .SEQ_W(32)) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .update_i   (update_i),
        .pc_i       (pc_i),
        .instr_i    (instr_i),
        .reg_addr_i (reg_addr_i),
        .reg_data_i (reg_data_i),
        .mem_wrt_i  (mem_wrt_i),
        .mem_addr_i (mem_addr_i),
        .mem_data_i (mem_data_i),
        .flush_i    (flush_i),
        .trace_if   (tif),
        .count_o    (count_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    riscv_pkg::trace_rec_t mq[$];
    logic [31:0] m_seq;
    int unsigned m_drop;
    bit          m_pend;
    logic [31:0] m_paddr, m_pdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_seq = 0; m_drop = 0; m_pend = 0; m_paddr = 0; m_pdata = 0;
    endtask

    // Applies the rules to the inputs seen at this clock edge.
    task automatic model_edge();
        riscv_pkg::trace_rec_t r;
        bit pop;
        if (!rstn_i) begin
            model_reset();
            return;
        end
        pop = (mq.size() != 0) && tif.trace_ready;
        r = '0;
        r.seq = m_seq; r.pc = pc_i; r.instr = instr_i;
        r.rd_we = (reg_addr_i != 0); r.rd = reg_addr_i; r.rd_data = reg_data_i;
        if (mem_wrt_i) begin
            r.mem_we = 1; r.mem_addr = mem_addr_i; r.mem_data = mem_data_i;
        end else if (m_pend) begin
            r.mem_we = 1; r.mem_addr = m_paddr; r.mem_data = m_pdata;
        end
        if (flush_i) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (update_i) begin
                if (mq.size() < DEPTH) mq.push_back(r);
                else if (m_drop < 16'hFFFF) m_drop++;
            end
        end
        if (update_i) m_seq = m_seq + 1;
        if (flush_i || update_i) m_pend = 0;
        else if (mem_wrt_i) begin
            m_pend = 1; m_paddr = mem_addr_i; m_pdata = mem_data_i;
        end
    endtask

    task automatic check_all();
        riscv_pkg::trace_rec_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk("valid", tif.trace_valid, mq.size() != 0);
        chk("count", count_o, mq.size());
        chk("drop", drop_cnt_o, m_drop);
        chk("seq", tif.trace_seq, h.seq);
        chk("pc", tif.trace_pc, h.pc);
        chk("instr", tif.trace_instr, h.instr);
        chk("rd_we", tif.trace_rd_we, h.rd_we);
        chk("rd", tif.trace_rd, h.rd);
        chk("rd_data", tif.trace_rd_data, h.rd_data);
        chk("mem_we", tif.trace_mem_we, h.mem_we);
        chk("mem_addr", tif.trace_mem_addr, h.mem_addr);
        chk("mem_data", tif.trace_mem_data, h.mem_data);
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        update_i = 0; mem_wrt_i = 0; flush_i = 0;
        pc_i = 0; instr_i = 0; reg_addr_i = 0; reg_data_i = 0; mem_addr_i = 0; mem_data_i = 0;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd,
                          input logic [31:0] data);
        update_i = 1; pc_i = pc; instr_i = instr; reg_addr_i = rd; reg_data_i = data;
        step();
        update_i = 0;
    endtask

    task automatic do_reset();
        #2 rstn_i = 0;
        model_reset();
        step();
        rstn_i = 1;
    endtask

    initial begin
        idle_inputs();
        tif.trace_ready = 0;
        rstn_i = 0;
        model_reset();
        #12 rstn_i = 1;
        #1 check_all();

        // Single retire, consumed by a ready sink.
        tif.trace_ready = 1;
        retire(32'h100, 32'h0050_0093, 5'd1, 32'd5);
        chk("t1_seq", tif.trace_seq, 0);
        chk("t1_rd_we", tif.trace_rd_we, 1);
        chk("t1_mem_we", tif.trace_mem_we, 0);
        step();
        chk("t1_count", count_o, 0);

        // Store two cycles before retirement is attached to that record only.
        mem_wrt_i = 1; mem_addr_i = 32'h2000; mem_data_i = 32'hDEAD_BEEF;
        step();
        mem_wrt_i = 0; mem_addr_i = 0; mem_data_i = 0;
        step();
        retire(32'h104, 32'h00A1_2023, 5'd0, 32'd0);
        chk("t2_mem_we", tif.trace_mem_we, 1);
        chk("t2_mem_addr", tif.trace_mem_addr, 32'h2000);
        chk("t2_mem_data", tif.trace_mem_data, 32'hDEAD_BEEF);
        retire(32'h108, 32'h0000_0013, 5'd0, 32'd0);
        chk("t2_next_mem_we", tif.trace_mem_we, 0);
        step();

        // Overflow under backpressure.
        do_reset();
        tif.trace_ready = 0;
        for (int i = 0; i < 10; i++) retire(32'h200 + 4 * i, $urandom, 5'(i + 1), $urandom);
        chk("t3_count", count_o, 8);
        chk("t3_drop", drop_cnt_o, 2);
        tif.trace_ready = 1;
        for (int i = 0; i < 8; i++) step();
        retire(32'h300, 32'h0000_0013, 5'd3, 32'd7);
        chk("t3_seq10", tif.trace_seq, 10);
        step();

        // Full FIFO with simultaneous push and pop.
        do_reset();
        tif.trace_ready = 0;
        for (int i = 0; i < 8; i++) retire(32'h400 + 4 * i, $urandom, 5'd2, $urandom);
        tif.trace_ready = 1;
        retire(32'h500, 32'h0000_0013, 5'd4, 32'd9);
        chk("t4_count", count_o, 8);
        chk("t4_drop", drop_cnt_o, 0);
        chk("t4_head_seq", tif.trace_seq, 1);

        // rd=0 retire, then flush with a same-cycle retire.
        do_reset();
        tif.trace_ready = 0;
        retire(32'h600, 32'h0000_0013, 5'd0, 32'd0);
        chk("t5_rd_we", tif.trace_rd_we, 0);
        for (int i = 0; i < 4; i++) retire(32'h604 + 4 * i, $urandom, 5'd5, $urandom);
        flush_i = 1;
        retire(32'h700, 32'h0000_0013, 5'd6, 32'd1);
        flush_i = 0;
        chk("t5_flush_count", count_o, 0);
        chk("t5_flush_valid", tif.trace_valid, 0);
        chk("t5_flush_drop", drop_cnt_o, 0);
        retire(32'h704, 32'h0000_0013, 5'd6, 32'd2);
        chk("t5_seq6", tif.trace_seq, 6);

        // Asynchronous reset while a record is held by a stalled sink.
        retire(32'h708, 32'h0000_0013, 5'd7, 32'd3);
        #1 rstn_i = 0;
        model_reset();
        #1;
        chk("t6_valid", tif.trace_valid, 0);
        chk("t6_pc", tif.trace_pc, 0);
        check_all();
        step();
        #2 rstn_i = 1;
        retire(32'h800, 32'h0000_0013, 5'd8, 32'd4);
        chk("t6_seq0", tif.trace_seq, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            update_i        = ($urandom_range(0, 1) == 1);
            mem_wrt_i       = ($urandom_range(0, 3) == 0);
            flush_i         = ($urandom_range(0, 29) == 0);
            tif.trace_ready = ($urandom_range(0, 2) != 0);
            pc_i            = $urandom;
            instr_i         = $urandom;
            reg_addr_i      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            reg_data_i      = $urandom;
            mem_addr_i      = $urandom;
            mem_data_i      = $urandom;
            step();
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/riscv_retire_tracer.md
Name: riscv_retire_tracer

Overview:
- Downstream consumer of the multicycle core's retirement and data-memory outputs.
- Captures one trace record per retired instruction: PC, instruction, rd write and any data-memory store issued during that instruction.
- Buffers records in a FIFO and streams them out over a valid/ready interface to a debug/log sink. Counts drops when the sink stalls.

Parameters:
- XLEN, 32, datapath width; must match the core.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- SEQ_W, 32, width of the retirement sequence counter.

Ports:
- clk_i  input  1  system clock
- rstn_i  input  1  reset, asynchronous, active-low
- update_i  input  1  core retirement strobe
- pc_i  input  XLEN  retired PC
- instr_i  input  XLEN  retired instruction
- reg_addr_i  input  5  retired rd
- reg_data_i  input  XLEN  value written to rd
- mem_wrt_i  input  1  data-memory write enable from core
- mem_addr_i  input  XLEN  data-memory address
- mem_data_i  input  XLEN  data-memory write data
- flush_i  input  1  synchronous FIFO/pending clear
- trace_valid_o  output  1  record available
- trace_ready_i  input  1  sink accepts record
- trace_seq_o  output  SEQ_W  record sequence number
- trace_pc_o  output  XLEN  record PC
- trace_instr_o  output  XLEN  record instruction
- trace_rd_we_o  output  1  record wrote a register (rd != 0)
- trace_rd_o  output  5  record rd
- trace_rd_data_o  output  XLEN  record rd value
- trace_mem_we_o  output  1  record contains a store
- trace_mem_addr_o  output  XLEN  store address
- trace_mem_data_o  output  XLEN  store data
- count_o  output  $clog2(DEPTH)+1  occupancy
- drop_cnt_o  output  16  dropped records, saturating

Behaviour:
- Clock clk_i; reset rstn_i asynchronous, active-low. On reset: FIFO empty, trace_valid_o=0, all trace_* data outputs 0, count_o=0, drop_cnt_o=0, seq counter=0, store-pending cleared.
- Store capture:
  - mem_wrt_i=1 while update_i=0: latch addr/data into the pending register and set pending. A later store before retirement overwrites it (last store wins).
  - On update_i=1, the record's store fields come from the current-cycle store if mem_wrt_i=1; otherwise from the pending register if pending=1; otherwise trace_mem_we=0 with addr/data=0.
  - pending clears on every update_i.
- Record build on update_i=1:
  - seq = current counter value, then the counter increments by 1 with wrap at 2^SEQ_W.
  - The counter increments even when the record is dropped, so gaps in seq expose loss.
  - rd_we = (reg_addr_i != 0).
- FIFO:
  - First-word-fall-through: trace_valid_o = (count != 0), and trace_* outputs reflect the head entry combinationally from storage.
  - When empty, data outputs are 0.
  - Pop when trace_valid_o && trace_ready_i. Push when update_i. Push latency: record visible at the output the cycle after update_i.
  - Full with push and no pop: record dropped; drop_cnt_o increments, saturating at 0xFFFF.
  - Full with push and pop in the same cycle: both happen, no drop, count unchanged.
  - Empty with push and ready=1: no bypass; the record appears next cycle.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally; full = MSBs differ and the rest is equal.
- flush_i (synchronous, priority over push/pop):
  - Empties the FIFO and clears pending.
  - A same-cycle update_i is discarded and not counted as a drop. The seq counter still increments.
  - drop_cnt_o is unchanged.
- Reset asserted mid-stream: immediate return to reset state regardless of the handshake.
- trace_valid_o must not drop without a pop, and the head record must not change while valid && !ready, except on flush_i or reset.

Decomposition:
- riscv_pkg gains trace_rec_t, a packed struct {seq, pc, instr, rd_we, rd, rd_data, mem_we, mem_addr, mem_data}, plus the TRACE_DROP_W=16 constant.
- One sub-module, trace_fifo: a generic FWFT synchronous FIFO parameterised on width/depth, with push/pop/flush, full/empty/count.
- Store-pending logic, seq counter and drop counter live in the top.

Test Plan:
- Single retire with ready=1: update_i pc=0x100, instr=0x00500093, rd=1, data=5 -> next cycle valid=1, seq=0, rd_we=1, mem_we=0; popped, then count=0.
- Store then retire: mem_wrt_i addr=0x2000 data=0xDEADBEEF at cycle t, update_i at t+2 -> record mem_we=1, addr=0x2000, data=0xDEADBEEF. Next record has mem_we=0.
- Backpressure overflow, DEPTH=8, ready=0: 10 retires -> count_o=8, drop_cnt_o=2. Draining yields seq 0..7, next retire gets seq=10.
- Full with simultaneous push+pop: fill 8, then update_i with ready=1 -> count stays 8, drop_cnt unchanged, head seq advances 0->1.
- rd=0 retire (instr 0x00000013) -> rd_we=0. Flush with 5 entries and a same-cycle update_i -> count_o=0, valid=0, drop_cnt unchanged, following record seq=6.
- Async reset asserted while valid=1, ready=0 -> outputs zero immediately. After release, first record has seq=0.
